// File: rtl/modulus_ggg_carry_normalizer.sv
// modulus_ggg_carry_normalizer: resolves redundant column sums into WORD_LEN-bit digits,
// rippling the carry one limb per clock from limb 0 upward.
module modulus_ggg_carry_normalizer #(
    parameter int NUM_LIMBS = 40,
    parameter int BIT_LEN   = 58,
    parameter int WORD_LEN  = 26,
    parameter int CARRY_LEN = BIT_LEN - WORD_LEN + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_LEN-1:0]   sums [NUM_LIMBS],
    input  logic [CARRY_LEN-1:0] carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_LEN-1:0]  digits [NUM_LIMBS],
    output logic [CARRY_LEN-1:0] carry_out
);
    localparam int IDX_W = $clog2(NUM_LIMBS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [BIT_LEN-1:0]   sum_reg [NUM_LIMBS];
    logic [CARRY_LEN-1:0] carry;
    logic [BIT_LEN:0]     t;
    logic                 accept, last;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid && in_ready;
    assign last      = idx == IDX_W'(NUM_LIMBS - 1);
    // one extra bit above BIT_LEN absorbs the carry add; it can never overflow
    assign t         = {1'b0, sum_reg[idx]} + (BIT_LEN + 1)'(carry);

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && accept)    ? RUN  :
                    (state == RUN  && last)      ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx       <= '0;
            carry     <= '0;
            carry_out <= '0;
            for (int i = 0; i < NUM_LIMBS; i++) digits[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_LIMBS; i++) sum_reg[i] <= sums[i];
            carry <= carry_in;
            idx   <= '0;
        end else if (state == RUN) begin
            digits[idx] <= t[WORD_LEN-1:0];
            carry       <= CARRY_LEN'(t[BIT_LEN:WORD_LEN]);
            idx         <= last ? idx : idx + IDX_W'(1);
            if (last) carry_out <= CARRY_LEN'(t[BIT_LEN:WORD_LEN]);
        end
    end
endmodule

// File: tb/tb_modulus_ggg_carry_normalizer.sv
// tb_modulus_ggg_carry_normalizer: directed vector table plus handshake/reset sequences
// and a big-integer invariant check against the original column sums.
module tb_modulus_ggg_carry_normalizer;
    localparam int NL = 40, BL = 58, WL = 26, CL = 33, BW = 1100;

    typedef struct {
        logic [BL-1:0] s0, s_rest;
        logic [CL-1:0] cin;
        logic [WL-1:0] d0, d1, d2, d_rest;
        logic [CL-1:0] cout;
    } vec_t;

    logic          clk = 0, reset_n = 0, in_valid = 0, out_ready = 0;
    logic          in_ready, out_valid;
    logic [BL-1:0] sums_in [NL];
    logic [BL-1:0] sums_ref [NL];
    logic [CL-1:0] cin_in = '0, cin_ref = '0, carry_out;
    logic [WL-1:0] digits [NL];
    int            n_vec = 0, n_bad = 0;
    vec_t          vecs [7];

    modulus_ggg_carry_normalizer dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .sums(sums_in), .carry_in(cin_in), .out_valid(out_valid), .out_ready(out_ready),
        .digits(digits), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] ref_val();
        logic [BW-1:0] acc = BW'(cin_ref);
        for (int i = 0; i < NL; i++) acc += BW'(sums_ref[i]) << (WL * i);
        return acc;
    endfunction

    function automatic logic [BW-1:0] dut_val();
        logic [BW-1:0] acc = BW'(carry_out) << (WL * NL);
        for (int i = 0; i < NL; i++) acc += BW'(digits[i]) << (WL * i);
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_txn();
        int w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        chk("in_ready_wait", BW'(w < 100), 1);
        in_valid = 1;
        sums_ref = sums_in;
        cin_ref  = cin_in;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin tick(); lat++; end
    endtask

    task automatic release_out();
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("release_out_valid", BW'(out_valid), 0);
        chk("release_in_ready", BW'(in_ready), 1);
    endtask

    task automatic rand_sums();
        for (int i = 0; i < NL; i++) sums_in[i] = {$urandom, $urandom} >> 6;
        cin_in = {$urandom, $urandom} >> 31;
    endtask

    initial begin
        int lat;
        logic [WL-1:0] ed;
        vecs[0] = '{s0: 0, s_rest: 0, cin: 0, d0: 0, d1: 0, d2: 0, d_rest: 0, cout: 0};
        vecs[1] = '{s0: 58'h4000005, s_rest: 0, cin: 0, d0: 5, d1: 1, d2: 0, d_rest: 0, cout: 0};
        vecs[2] = '{s0: {BL{1'b1}}, s_rest: {BL{1'b1}}, cin: 0, d0: 26'h3FFFFFF,
                    d1: 26'h3FFFFFE, d2: 26'h3E, d_rest: 26'h3F, cout: 33'h100000040};
        vecs[3] = '{s0: 0, s_rest: 0, cin: 7, d0: 7, d1: 0, d2: 0, d_rest: 0, cout: 0};
        vecs[4] = '{s0: 1, s_rest: 1, cin: 0, d0: 1, d1: 1, d2: 1, d_rest: 1, cout: 0};
        vecs[5] = '{s0: 0, s_rest: 0, cin: {CL{1'b1}}, d0: 26'h3FFFFFF, d1: 26'h7F,
                    d2: 0, d_rest: 0, cout: 0};
        vecs[6] = '{s0: {BL{1'b1}}, s_rest: 0, cin: {CL{1'b1}}, d0: 26'h3FFFFFE,
                    d1: 26'h7F, d2: 26'h40, d_rest: 0, cout: 0};
        for (int i = 0; i < NL; i++) sums_in[i] = '0;

        tick(); tick();
        reset_n = 1;
        tick();
        chk("reset_in_ready", BW'(in_ready), 1);
        chk("reset_out_valid", BW'(out_valid), 0);
        chk("reset_value", dut_val(), 0);

        for (int v = 0; v < 7; v++) begin
            sums_in[0] = vecs[v].s0;
            for (int i = 1; i < NL; i++) sums_in[i] = vecs[v].s_rest;
            cin_in = vecs[v].cin;
            accept_txn();
            for (int i = 0; i < NL; i++) sums_in[i] = '1;
            cin_in = '1;
            wait_done(lat);
            chk($sformatf("v%0d_latency", v), BW'(lat), NL + 1);
            for (int i = 0; i < NL; i++) begin
                ed = i == 0 ? vecs[v].d0 : i == 1 ? vecs[v].d1 : i == 2 ? vecs[v].d2 : vecs[v].d_rest;
                chk($sformatf("v%0d_digit%0d", v, i), BW'(digits[i]), BW'(ed));
            end
            chk($sformatf("v%0d_carry_out", v), BW'(carry_out), BW'(vecs[v].cout));
            chk($sformatf("v%0d_invariant", v), dut_val(), ref_val());
            release_out();
        end

        // back-pressure: result held, new requests ignored
        rand_sums();
        accept_txn();
        wait_done(lat);
        for (int c = 0; c < 10; c++) begin
            rand_sums();
            in_valid = 1;
            tick();
            chk("stall_out_valid", BW'(out_valid), 1);
            chk("stall_in_ready", BW'(in_ready), 0);
            chk("stall_value", dut_val(), ref_val());
        end
        in_valid = 0;
        release_out();
        rand_sums();
        accept_txn();
        wait_done(lat);
        chk("post_stall_latency", BW'(lat), NL + 1);
        chk("post_stall_value", dut_val(), ref_val());
        release_out();

        // reset mid-RUN at idx 5
        for (int i = 0; i < NL; i++) sums_in[i] = '1;
        cin_in = '1;
        accept_txn();
        repeat (5) tick();
        chk("midrun_out_valid", BW'(out_valid), 0);
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("midrun_rst_in_ready", BW'(in_ready), 1);
        chk("midrun_rst_out_valid", BW'(out_valid), 0);
        chk("midrun_rst_value", dut_val(), 0);
        rand_sums();
        accept_txn();
        wait_done(lat);
        chk("after_rst_value", dut_val(), ref_val());
        release_out();

        // random traffic with input and output gaps
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            rand_sums();
            accept_txn();
            wait_done(lat);
            chk("rnd_latency", BW'(lat), NL + 1);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd_hold_in_ready", BW'(in_ready), 0);
            end
            chk("rnd_out_valid", BW'(out_valid), 1);
            chk("rnd_invariant", dut_val(), ref_val());
            release_out();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
